// File: rtl/cam_capture_ctrl_pkg.sv
// cam_capture_ctrl_pkg: shared types and constants for the camera capture path.
// Holds the capture FSM states, default frame geometry and RGB565 colours.
package cam_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    WAIT_VS_END,
    ACTIVE
  } cap_state_e;

  // Frame geometry shared with the VGA read-address logic
  localparam int CAM_W = 176;
  localparam int CAM_H = 144;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// cam_capture_ctrl_if: frame-buffer write port (address, pixel, strobe).
// master = capture sequencer, slave = buffer / observer.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] W_ADDR;
  logic [15:0]       W_DATA;
  logic              W_EN;

  modport master (output W_ADDR, W_DATA, W_EN);
  modport slave  (input  W_ADDR, W_DATA, W_EN);
endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: N-stage synchronizer for a bus plus registered edge strobes.
// Ports: d_i async bus in; q_o synced bus; rise_o/fall_o edges of top EW bits.
module cam_sync_edge #(
  parameter int W  = 11,
  parameter int EW = 3,
  parameter int N  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  d_i,
  output logic [W-1:0]  q_o,
  output logic [EW-1:0] rise_o,
  output logic [EW-1:0] fall_o
);

  logic [W-1:0]  s_q [N];
  logic [W-1:0]  q_q;
  logic [EW-1:0] rise_q;
  logic [EW-1:0] fall_q;
  logic [EW-1:0] cur;
  logic [EW-1:0] old;

  assign cur = s_q[N-1][W-1 -: EW];
  assign old = q_q[W-1 -: EW];

  // q_q is both the previous value and the bus aligned with the strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) s_q[i] <= '0;
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < N; i++) s_q[i] <= s_q[i-1];
      q_q    <= s_q[N-1];
      rise_q <= cur & ~old;
      fall_q <= ~cur & old;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: oversampled RGB565 camera capture into a frame buffer.
// Ports: CLK/RESET_N; PCLK/VSYNC/HREF/DATA camera; START/CONTINUOUS arm;
// wr buffer write port; BUSY, FRAME_DONE, FRAME_ERR, FRAME_CNT status.
module cam_capture_ctrl
  import cam_capture_ctrl_pkg::*;
#(
  parameter int WIDTH       = CAM_W,
  parameter int HEIGHT      = CAM_H,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                PCLK,
  input  logic                VSYNC,
  input  logic                HREF,
  input  logic [7:0]          DATA,
  input  logic                START,
  input  logic                CONTINUOUS,
  cam_capture_ctrl_if.master  wr,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                FRAME_ERR,
  output logic [7:0]          FRAME_CNT
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT);
  localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(WIDTH);

  logic [10:0] bus_q;
  logic [2:0]  rise;
  logic [2:0]  fall;

  cam_sync_edge #(
    .W  (11),
    .EW (3),
    .N  (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .d_i    ({PCLK, VSYNC, HREF, DATA}),
    .q_o    (bus_q),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic       pclk_rise, vs_rise, vs_fall, href_fall;
  logic       vs_lvl, href_lvl;
  logic [7:0] data;
  logic       unused_bits;

  assign pclk_rise   = rise[2];
  assign vs_rise     = rise[1];
  assign vs_fall     = fall[1];
  assign href_fall   = fall[0];
  assign vs_lvl      = bus_q[9];
  assign href_lvl    = bus_q[8];
  assign data        = bus_q[7:0];
  assign unused_bits = ^{bus_q[10], rise[0], fall[2]};

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ph_q, ph_d;
  logic [7:0]        lo_q, lo_d;
  logic              err_q, err_d;
  logic              xov_q, xov_d;
  logic              yov_q, yov_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      ph_q    <= 1'b0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      xov_q   <= 1'b0;
      yov_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      ph_q    <= ph_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      xov_q   <= xov_d;
      yov_q   <= yov_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    ph_d    = ph_q;
    lo_d    = lo_q;
    err_d   = err_q;
    xov_d   = xov_q;
    yov_d   = yov_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (START) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_lvl) state_d = WAIT_VS_END;
      end
      WAIT_VS_END: begin
        if (vs_fall) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          ph_d    = 1'b0;
          err_d   = 1'b0;
          xov_d   = 1'b0;
          yov_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (pclk_rise && href_lvl) begin
          if (!ph_q) begin
            lo_d = data;
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (x_q < XMAX && y_q < YMAX) begin
              wen_d   = 1'b1;
              waddr_d = base_q + ADDR_W'(x_q);
              wdata_d = {data, lo_q};
            end
            // x holds at WIDTH; xov remembers the line ran long
            if (x_q < XMAX) x_d = x_q + 1'b1;
            else            xov_d = 1'b1;
          end
        end
        // href_lvl is low here, so no byte event shares this cycle
        if (href_fall) begin
          if (x_q != XMAX || xov_q || ph_q) err_d = 1'b1;
          x_d   = '0;
          ph_d  = 1'b0;
          xov_d = 1'b0;
          if (y_q < YMAX) begin
            y_d    = y_q + 1'b1;
            base_d = base_q + WSTEP;
          end else begin
            yov_d = 1'b1;
          end
        end
        // Uses the _d values so a same-cycle HREF fall is counted first
        if (vs_rise) begin
          ferr_d  = err_d | (y_d != YMAX) | yov_d;
          err_d   = ferr_d;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = CONTINUOUS ? WAIT_VS_END : IDLE;
        end
      end
    endcase
  end

  assign wr.W_ADDR  = waddr_q;
  assign wr.W_DATA  = wdata_q;
  assign wr.W_EN    = wen_q;
  assign BUSY       = (state_q != IDLE);
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = ferr_q;
  assign FRAME_CNT  = cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: scoreboard bench for cam_capture_ctrl.
// Drives a small camera model and checks writes and frame status.
module tb_cam_capture_ctrl;
  import cam_capture_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int H  = 7;
  localparam int AW = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pclk, vsync, href;
  logic [7:0] data;
  logic       start, cont;
  logic       busy, fdone, ferr;
  logic [7:0] fcnt;

  cam_capture_ctrl_if #(.ADDR_W(AW)) wr ();

  cam_capture_ctrl #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .ADDR_W      (AW),
    .SYNC_STAGES (2)
  ) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .PCLK       (pclk),
    .VSYNC      (vsync),
    .HREF       (href),
    .DATA       (data),
    .START      (start),
    .CONTINUOUS (cont),
    .wr         (wr),
    .BUSY       (busy),
    .FRAME_DONE (fdone),
    .FRAME_ERR  (ferr),
    .FRAME_CNT  (fcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  typedef struct {
    logic       e;
    logic [7:0] c;
  } dn_t;

  wr_t sb[$];
  dn_t dq[$];
  int  total = 0;
  int  bad   = 0;
  int  exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    dn_t f;
    if (rst_n) begin
      if (wr.W_EN) begin
        if (sb.size() == 0) begin
          chk("wr_unexp", 32'(sb.size()), 32'd1);
        end else begin
          w = sb.pop_front();
          chk("wr_addr", 32'(wr.W_ADDR), 32'(w.a));
          chk("wr_data", 32'(wr.W_DATA), 32'(w.d));
        end
      end
      if (fdone) begin
        if (dq.size() == 0) begin
          chk("done_unexp", 32'(dq.size()), 32'd1);
        end else begin
          f = dq.pop_front();
          chk("f_err", 32'(ferr), 32'(f.e));
          chk("f_cnt", 32'(fcnt), 32'(f.c));
        end
      end
    end
  end

  task automatic pclk_cyc();
    pclk = 1'b0;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_start();
    chk("busy_pre", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_wen",  32'(wr.W_EN),   32'd0);
    chk("rst_addr", 32'(wr.W_ADDR), 32'd0);
    chk("rst_data", 32'(wr.W_DATA), 32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_done", 32'(fdone),     32'd0);
    chk("rst_ferr", 32'(ferr),      32'd0);
    chk("rst_cnt",  32'(fcnt),      32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic vs_end();
    vsync = 1'b1;
    repeat (3) pclk_cyc();
    vsync = 1'b0;
    repeat (3) pclk_cyc();
  endtask

  // nl lines of np pixels; odd_l line is one byte short; arm_l/rst_l
  // pulse START/reset at that line; push enables expectations.
  task automatic send_frame(input int nl, input int np, input int odd_l,
                            input bit push_i, input int arm_l,
                            input int rst_l);
    bit push;
    int nb;
    push  = push_i;
    vsync = 1'b1;
    repeat (3) pclk_cyc();
    vsync = 1'b0;
    repeat (2) pclk_cyc();
    for (int y = 0; y < nl; y++) begin
      if (y == arm_l) do_start();
      if (y == rst_l) begin
        do_reset();
        push = 1'b0;
      end
      nb   = (y == odd_l) ? 2 * np - 1 : 2 * np;
      href = 1'b1;
      for (int b = 0; b < nb; b++) begin
        int x;
        x    = b / 2;
        data = (b % 2 == 0) ? 8'(x) : 8'(y);
        if (b % 2 == 1 && push && x < W && y < H)
          sb.push_back('{a: AW'(y * W + x), d: {8'(y), 8'(x)}});
        pclk_cyc();
      end
      href = 1'b0;
      repeat (2) pclk_cyc();
    end
    if (push) begin
      exp_cnt++;
      dq.push_back('{e: (nl != H) || (np != W) ||
                        (odd_l >= 0 && odd_l < nl),
                     c: 8'(exp_cnt)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    pclk  = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    data  = 8'h00;
    start = 1'b0;
    cont  = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_wen",  32'(wr.W_EN),   32'd0);
    chk("init_addr", 32'(wr.W_ADDR), 32'd0);
    chk("init_busy", 32'(busy),      32'd0);
    chk("init_cnt",  32'(fcnt),      32'd0);
    chk("init_done", 32'(fdone),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_start();
    send_frame(H, W, -1, 1'b1, -1, -1);
    vs_end();
    chk("busy_single", 32'(busy), 32'd0);

    do_start();
    send_frame(H + 2, W + 2, -1, 1'b1, -1, -1);
    vs_end();

    do_start();
    send_frame(H, W, 5, 1'b1, -1, -1);
    vs_end();

    cont = 1'b1;
    do_start();
    for (int f = 0; f < 3; f++) begin
      send_frame(H, W, -1, 1'b1, -1, -1);
      chk("busy_cont", 32'(busy), 32'd1);
    end
    cont = 1'b0;
    vs_end();
    chk("busy_cont_end", 32'(busy), 32'd0);

    send_frame(H, W, -1, 1'b0, 2, -1);
    send_frame(H, W, -1, 1'b1, -1, -1);
    vs_end();

    do_start();
    send_frame(H, W, -1, 1'b1, -1, 3);
    chk("busy_after_rst", 32'(busy), 32'd0);
    do_start();
    send_frame(H, W, -1, 1'b1, -1, -1);
    vs_end();

    repeat (20) @(negedge clk);
    chk("sb_left",   32'(sb.size()), 32'd0);
    chk("done_left", 32'(dq.size()), 32'd0);
    chk("final_cnt", 32'(fcnt), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
